// File: rtl/neuron_bank_sequencer_pkg.sv
// Shared bank register map, sequencer state encoding and a priority helper
// used by the neuron bank timestep sequencer.
package neuron_bank_sequencer_pkg;

   localparam int unsigned CFG_STRIDE   = 8;
   localparam int unsigned CTRL_OFS     = 6;
   localparam int unsigned RESOLVE_OFS  = 7;
   localparam int unsigned INPUT_BASE   = 'h80;
   localparam int unsigned SPIKE_STATUS = 'hC2;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_WR_IN,
      S_WR_START,
      S_POLL_RD,
      S_POLL_WAIT,
      S_STAT_RD,
      S_STAT_WAIT,
      S_EMIT,
      S_RESOLVE,
      S_DONE
   } state_e;

   // Index of the lowest set bit; 0 for an empty vector.
   function automatic logic [4:0] lowest_set(input logic [31:0] m);
      logic [4:0] idx;
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (m[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/neuron_bank_sequencer.sv
// Runs one timestep on a neuron bank: loads input currents, kicks every neuron,
// polls for completion, then emits and resolves each pending spike in index order.
module neuron_bank_sequencer
   import neuron_bank_sequencer_pkg::*;
#(
   parameter int unsigned NUM_NEURONS = 4,
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned POLL_LIMIT  = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  step_start,
   input  logic                  cur_valid,
   output logic                  cur_ready,
   input  logic [31:0]           cur_data,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  read_enable,
   output logic                  write_enable,
   output logic [31:0]           write_data,
   input  logic [31:0]           read_data,
   input  logic                  ready,
   output logic                  spike_valid,
   input  logic                  spike_ready,
   output logic [4:0]            spike_id,
   output logic                  active,
   output logic                  step_done,
   output logic [5:0]            spike_count,
   output logic                  timeout_err
);

   localparam int unsigned   PW       = $clog2(POLL_LIMIT + 2);
   localparam logic [4:0]    LAST_N   = 5'(NUM_NEURONS - 1);
   localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);

   state_e                 state_q, state_d;
   logic [4:0]             n_q, n_d;
   logic [31:0]            data_q, data_d;
   logic [PW-1:0]          poll_q, poll_d;
   logic [NUM_NEURONS-1:0] mask_q, mask_d, mask_nx, rd_mask;
   logic [4:0]             id_q, id_d;
   logic [5:0]             cnt_q, cnt_d;
   logic                   tout_q, tout_d;

   function automatic logic [ADDR_WIDTH-1:0] cfg_addr(input logic [4:0] idx,
                                                       input int unsigned ofs);
      return ADDR_WIDTH'(32'(idx) * CFG_STRIDE + ofs);
   endfunction

   // Upper status bits belong to neurons this bank does not have.
   assign rd_mask     = read_data[NUM_NEURONS-1:0];
   assign spike_id    = id_q;
   assign spike_count = cnt_q;
   assign timeout_err = tout_q;
   assign active      = (state_q != S_IDLE) && (state_q != S_DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         data_q  <= '0;
         poll_q  <= '0;
         mask_q  <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         data_q  <= data_d;
         poll_q  <= poll_d;
         mask_q  <= mask_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         tout_q  <= tout_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      data_d       = data_q;
      poll_d       = poll_q;
      mask_d       = mask_q;
      id_d         = id_q;
      cnt_d        = cnt_q;
      tout_d       = tout_q;
      cur_ready    = 1'b0;
      address      = '0;
      read_enable  = 1'b0;
      write_enable = 1'b0;
      write_data   = '0;
      spike_valid  = 1'b0;
      step_done    = 1'b0;

      mask_nx = mask_q;
      for (int i = 0; i < NUM_NEURONS; i++) begin
         if (5'(i) == id_q) mask_nx[i] = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (step_start) begin
               n_d     = '0;
               cnt_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            cur_ready = 1'b1;
            if (cur_valid) begin
               data_d  = cur_data;
               state_d = S_WR_IN;
            end
         end
         S_WR_IN: begin
            address    = ADDR_WIDTH'(INPUT_BASE + 32'(n_q));
            write_data = data_q;
            if (ready) begin
               write_enable = 1'b1;
               if (n_q == LAST_N) begin
                  n_d     = '0;
                  state_d = S_WR_START;
               end else begin
                  n_d     = n_q + 5'd1;
                  state_d = S_LOAD;
               end
            end
         end
         S_WR_START: begin
            address    = cfg_addr(n_q, CTRL_OFS);
            write_data = 32'd1;
            if (ready) begin
               write_enable = 1'b1;
               if (n_q == LAST_N) begin
                  n_d     = '0;
                  state_d = S_POLL_RD;
               end else begin
                  n_d = n_q + 5'd1;
               end
            end
         end
         S_POLL_RD: begin
            address = cfg_addr(n_q, CTRL_OFS);
            if (ready) begin
               read_enable = 1'b1;
               poll_d      = poll_q + 1'b1;
               state_d     = S_POLL_WAIT;
            end
         end
         S_POLL_WAIT: begin
            address = cfg_addr(n_q, CTRL_OFS);
            // A neuron still busy at the poll limit is abandoned, not retried.
            if (!read_data[0] || poll_q >= POLL_MAX) begin
               if (read_data[0]) tout_d = 1'b1;
               poll_d = '0;
               if (n_q == LAST_N) begin
                  n_d     = '0;
                  state_d = S_STAT_RD;
               end else begin
                  n_d     = n_q + 5'd1;
                  state_d = S_POLL_RD;
               end
            end else begin
               state_d = S_POLL_RD;
            end
         end
         S_STAT_RD: begin
            address = ADDR_WIDTH'(SPIKE_STATUS);
            if (ready) begin
               read_enable = 1'b1;
               state_d     = S_STAT_WAIT;
            end
         end
         S_STAT_WAIT: begin
            mask_d = rd_mask;
            if (|rd_mask) begin
               id_d    = lowest_set(32'(rd_mask));
               state_d = S_EMIT;
            end else begin
               state_d = S_DONE;
            end
         end
         S_EMIT: begin
            spike_valid = 1'b1;
            if (spike_ready) begin
               cnt_d   = cnt_q + 6'd1;
               state_d = S_RESOLVE;
            end
         end
         S_RESOLVE: begin
            address    = cfg_addr(id_q, RESOLVE_OFS);
            write_data = 32'd1;
            if (ready) begin
               write_enable = 1'b1;
               mask_d       = mask_nx;
               if (|mask_nx) begin
                  id_d    = lowest_set(32'(mask_nx));
                  state_d = S_EMIT;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            step_done = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_neuron_bank_sequencer.sv
// Directed bench: a bank model answers reads, and every bus strobe and spike
// transfer is compared in order against a queue of expected transactions.
module tb_neuron_bank_sequencer;

   localparam int NN = 4;
   localparam int AW = 8;
   localparam int PL = 4;

   localparam logic [1:0] K_WR = 2'd1;
   localparam logic [1:0] K_RD = 2'd2;
   localparam logic [1:0] K_SP = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [7:0]  addr;
      logic [31:0] data;
   } txn_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          step_start = 1'b0;
   logic          cur_valid = 1'b0;
   logic          cur_ready;
   logic [31:0]   cur_data = '0;
   logic [AW-1:0] address;
   logic          read_enable, write_enable;
   logic [31:0]   write_data;
   logic [31:0]   read_data = '0;
   logic          ready = 1'b1;
   logic          spike_valid;
   logic          spike_ready = 1'b1;
   logic [4:0]    spike_id;
   logic          active, step_done;
   logic [5:0]    spike_count;
   logic          timeout_err;

   neuron_bank_sequencer #(.NUM_NEURONS(NN), .ADDR_WIDTH(AW), .POLL_LIMIT(PL)) dut (
      .clk(clk), .rst_n(rst_n), .step_start(step_start),
      .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_data(cur_data),
      .address(address), .read_enable(read_enable), .write_enable(write_enable),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_id(spike_id),
      .active(active), .step_done(step_done), .spike_count(spike_count),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          errs = 0;
   txn_t        exp_q[$];
   logic [31:0] curs[8];
   int          cur_idx = 0;
   int          busy_left[NN];
   bit          stuck = 1'b0;
   logic [31:0] stat_word = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb(input logic [1:0] k, input logic [7:0] a, input logic [31:0] d);
      txn_t e;
      if (exp_q.size() == 0) begin
         vectors++;
         assert (exp_q.size() != 0) else begin
            errs++;
            $error("FAIL unexpected_txn: observed kind %0d addr %h data %h expected none", k, a, d);
         end
      end else begin
         e = exp_q.pop_front();
         check("bus_txn", 64'({k, a, d}), 64'(e));
      end
   endtask

   task automatic push(input logic [1:0] k, input int a, input logic [31:0] d);
      txn_t e;
      e.kind = k;
      e.addr = 8'(a);
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Bus monitor and bank model: read data appears mid-cycle of the read and
   // is held through the following cycle, where the sequencer samples it.
   always @(negedge clk) begin
      if (active === 1'b1) check("strobe_excl", 64'(read_enable & write_enable), 64'd0);
      if (ready === 1'b0 && active === 1'b1)
         check("strobe_while_not_ready", 64'({read_enable, write_enable}), 64'd0);
      if (write_enable === 1'b1) sb(K_WR, address, write_data);
      if (read_enable === 1'b1) begin
         sb(K_RD, address, 32'd0);
         if (address == 8'hC2) begin
            read_data = stat_word;
         end else if (stuck) begin
            read_data = 32'd1;
         end else if (busy_left[int'(address >> 3) % NN] > 0) begin
            busy_left[int'(address >> 3) % NN]--;
            read_data = 32'd1;
         end else begin
            read_data = 32'hFFFF_FFFE;
         end
      end
      if (spike_valid === 1'b1 && spike_ready === 1'b1) sb(K_SP, 8'(spike_id), 32'd0);
   end

   // Current source: always valid, advances after every accepted transfer.
   initial begin
      forever begin
         @(negedge clk);
         if (cur_valid && cur_ready === 1'b1) begin
            @(posedge clk);
            #1;
            cur_idx++;
            cur_data = curs[cur_idx];
         end
      end
   end

   task automatic plan_step(input logic [NN-1:0] mask, input logic [27:0] junk);
      int reps;
      for (int i = 0; i < NN; i++) push(K_WR, 'h80 + i, curs[i]);
      for (int i = 0; i < NN; i++) push(K_WR, i * 8 + 6, 32'd1);
      for (int i = 0; i < NN; i++) begin
         reps = stuck ? PL : busy_left[i] + 1;
         for (int r = 0; r < reps; r++) push(K_RD, i * 8 + 6, 32'd0);
      end
      push(K_RD, 'hC2, 32'd0);
      for (int i = 0; i < NN; i++) begin
         if (mask[i]) begin
            push(K_SP, i, 32'd0);
            push(K_WR, i * 8 + 7, 32'd1);
         end
      end
      stat_word = {junk, mask};
   endtask

   task automatic start_step();
      @(posedge clk);
      #1;
      cur_idx    = 0;
      cur_data   = curs[0];
      cur_valid  = 1'b1;
      step_start = 1'b1;
      @(posedge clk);
      #1;
      step_start = 1'b0;
      @(negedge clk);
      check("active_after_start", 64'(active), 64'd1);
   endtask

   task automatic finish_step(input int exp_cnt, input logic exp_tout);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         @(negedge clk);
         if (step_done === 1'b1) seen = 1'b1;
      end
      check("step_done_seen", 64'(seen), 64'd1);
      if (seen) begin
         check("spike_count", 64'(spike_count), 64'(exp_cnt));
         check("timeout_err", 64'(timeout_err), 64'(exp_tout));
         check("active_at_done", 64'(active), 64'd0);
      end
      check("txns_outstanding", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic wait_spike_valid();
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 1000 && !seen; c++) begin
         @(negedge clk);
         if (spike_valid === 1'b1) seen = 1'b1;
      end
      check("spike_valid_seen", 64'(seen), 64'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check(tag, 64'({address, read_enable, write_enable, write_data, spike_valid, spike_id,
                      active, step_done, spike_count, timeout_err, cur_ready}), 64'd0);
   endtask

   initial begin
      bit seen;
      curs[0] = 32'h3F80_0000;
      curs[1] = 32'h4000_0000;
      curs[2] = 32'h4040_0000;
      curs[3] = 32'h4080_0000;
      for (int i = 4; i < 8; i++) curs[i] = 32'hDEAD_0000 + 32'(i);
      for (int i = 0; i < NN; i++) busy_left[i] = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset_outputs");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Idle, no spikes.
      plan_step(4'b0000, 28'h0);
      start_step();
      finish_step(0, 1'b0);

      // Two spikes; junk above NUM_NEURONS must be ignored.
      plan_step(4'b1010, 28'hFFF_FFFF);
      start_step();
      finish_step(2, 1'b0);

      // Consumer stalls on the first spike for 5 cycles.
      spike_ready = 1'b0;
      plan_step(4'b0110, 28'h5A5_A5A5);
      start_step();
      wait_spike_valid();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("held_valid", 64'(spike_valid), 64'd1);
         check("held_id", 64'(spike_id), 64'd1);
      end
      @(posedge clk);
      #1 spike_ready = 1'b1;
      finish_step(2, 1'b0);

      // Neuron 2 busy for three polls.
      busy_left[2] = 3;
      plan_step(4'b0001, 28'h0);
      start_step();
      finish_step(1, 1'b0);

      // Every neuron stuck busy: each times out after PL polls.
      stuck = 1'b1;
      plan_step(4'b1000, 28'h0);
      start_step();
      finish_step(1, 1'b1);
      stuck = 1'b0;

      // Bank not ready during the start writes, then reset while emitting.
      spike_ready = 1'b0;
      plan_step(4'b0100, 28'h0);
      start_step();
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         if (write_enable === 1'b1 && address == 8'h83) seen = 1'b1;
      end
      check("last_input_write_seen", 64'(seen), 64'd1);
      @(posedge clk);
      #1 ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("stall_addr", 64'(address), 64'h06);
         check("stall_no_write", 64'(write_enable), 64'd0);
      end
      @(posedge clk);
      #1 ready = 1'b1;
      wait_spike_valid();
      check("emit_id", 64'(spike_id), 64'd2);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_idle_outputs("mid_step_reset_outputs");
      check("abandoned_txns", 64'(exp_q.size()), 64'd2);
      exp_q.delete();
      @(posedge clk);
      #1 begin
         rst_n = 1'b1;
         spike_ready = 1'b1;
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("idle_after_reset");

      // Clean step after the abandoned one.
      plan_step(4'b1001, 28'h0);
      start_step();
      finish_step(2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected completion before 500000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/neuron_bank_sequencer.md
NEURON_BANK_SEQUENCER -- requirements
Module: neuron_bank_sequencer

Interface
REQ-001 Parameter NUM_NEURONS, default 4, number of neurons in the target bank (1..32).
REQ-002 Parameter ADDR_WIDTH, default 8, bank register address width.
REQ-003 Parameter POLL_LIMIT, default 255, maximum busy-poll reads per neuron before timeout.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 step_start  in  1  one-cycle request to run one timestep.
REQ-008 cur_valid / cur_ready  in / out  1 / 1  input-current handshake.
REQ-009 cur_data  in  32  IEEE-754 input current; currents arrive in neuron order 0..NUM_NEURONS-1.
REQ-010 address  out  ADDR_WIDTH  bank register address.
REQ-011 read_enable / write_enable  out  1 / 1  one-cycle bus strobes, never both high.
REQ-012 write_data  out  32  bank write data.
REQ-013 read_data  in  32  bank read data, valid the cycle after read_enable.
REQ-014 ready  in  1  bank ready; strobes issue only while ready=1.
REQ-015 spike_valid / spike_ready  out / in  1 / 1  spike-event handshake.
REQ-016 spike_id  out  5  index of the spiking neuron.
REQ-017 active  out  1  high from step acceptance until step_done.
REQ-018 step_done  out  1  one-cycle pulse at the end of a step.
REQ-019 spike_count  out  6  spikes emitted in the last step, valid with step_done.
REQ-020 timeout_err  out  1  sticky; set when a poll exceeds POLL_LIMIT.

Function
REQ-021 States: IDLE, LOAD, WR_IN, WR_START, POLL_RD, POLL_WAIT, STAT_RD, STAT_WAIT, EMIT, RESOLVE, DONE.
REQ-022 IDLE: step_start=1 -> LOAD, with neuron index n=0 and spike_count=0; step_start is ignored in every other state.
REQ-023 LOAD: cur_ready=1; a transfer (cur_valid & cur_ready) latches cur_data -> WR_IN.
REQ-024 WR_IN: write_enable with address=0x80+n and the latched data; if n<NUM_NEURONS-1, then n++ -> LOAD, else n=0 -> WR_START.
REQ-025 WR_START: write address=n*8+6, data=1, once for each neuron, one per cycle; after the last write, n=0 -> POLL_RD.
REQ-026 POLL_RD: read_enable at n*8+6 and increment the poll counter -> POLL_WAIT.
REQ-027 POLL_WAIT: if read_data[0]=0, then n++ with poll counter cleared, going to POLL_RD, or to STAT_RD after the last neuron.
REQ-028 POLL_WAIT busy=1: if the counter is below POLL_LIMIT -> POLL_RD; otherwise set timeout_err and advance as if idle.
REQ-029 STAT_RD: read_enable at 0xC2 -> STAT_WAIT; STAT_WAIT latches read_data[NUM_NEURONS-1:0] as the pending mask.
REQ-030 The lowest set bit of the mask is served first -> EMIT; an empty mask -> DONE.
REQ-031 EMIT: spike_valid=1 with spike_id; both stay stable until spike_ready; on the transfer, spike_count++ -> RESOLVE.
REQ-032 RESOLVE: write address=id*8+7, data=1, clear that mask bit -> EMIT for the next set bit, or DONE if none remain.
REQ-033 DONE: step_done=1 for one cycle, active=0 -> IDLE.
REQ-034 ready=0: the pending strobe is held back with state and address unchanged; a read result is sampled only in the cycle following an issued read_enable.
REQ-035 Bits of read_data at or above NUM_NEURONS are ignored.

Reset
REQ-036 With rst_n=0 at a clock edge, the state SHALL go to IDLE and all outputs, counters, the mask and timeout_err SHALL be cleared to 0.
REQ-037 Reset mid-step SHALL abandon the step without completing any bus transaction or spike handshake.

Structure
REQ-038 A shared package SHALL hold the bank address constants: config stride 8, control offset 6, resolve offset 7, input base 0x80, spike status 0xC2.
REQ-039 The state enumeration SHALL live in the same shared package.
REQ-040 The block SHALL be a single FSM with no sub-modules.

Verification
REQ-041 NUM_NEURONS=4, currents 1.0..4.0 always valid, busy=0, mask=0 -> writes 0x80..0x83, then 0x06/0x0E/0x16/0x1E, then step_done with spike_count=0.
REQ-042 Spike mask 0b1010 -> spike_id 1 then 3, resolve writes 0x0F and 0x1F, spike_count=2.
REQ-043 spike_ready held low 5 cycles -> spike_valid and spike_id stable, no resolve write until the handshake.
REQ-044 Neuron 2 busy for 3 reads -> 4 reads at 0x16, then the status read; timeout_err stays 0.
REQ-045 POLL_LIMIT=4 with busy stuck at 1 -> timeout_err=1 after 4 reads and the step still completes.
REQ-046 ready=0 for 3 cycles during WR_START, then reset asserted in EMIT -> no strobe while ready is low, then IDLE with all outputs 0.
